// File: rtl/cpu_seq_pkg.sv
// rtl/cpu_seq_pkg.sv - shared command, state and ALU opcode definitions for the CPU bus sequencer
package cpu_seq_pkg;

   typedef enum logic [1:0] {
      CMD_WRITE   = 2'd0,
      CMD_READ    = 2'd1,
      CMD_ALU     = 2'd2,
      CMD_ALU_REG = 2'd3
   } cmd_type_e;

   typedef enum logic [2:0] {
      S_IDLE    = 3'd0,
      S_WR_STB  = 3'd1,
      S_WR_HOLD = 3'd2,
      S_RD_STB  = 3'd3,
      S_RD_CAP  = 3'd4,
      S_ALU_SET = 3'd5,
      S_ALU_CAP = 3'd6,
      S_RSP     = 3'd7
   } seq_state_e;

   // Opcode encoding understood by the datapath ALU
   localparam logic [3:0] ALU_ADD    = 4'h0;
   localparam logic [3:0] ALU_SUB    = 4'h1;
   localparam logic [3:0] ALU_AND    = 4'h2;
   localparam logic [3:0] ALU_OR     = 4'h3;
   localparam logic [3:0] ALU_XOR    = 4'h4;
   localparam logic [3:0] ALU_PASS_A = 4'h5;

endpackage

// File: rtl/cpu_strobe_dec.sv
// rtl/cpu_strobe_dec.sv - register index plus enable to active-low one-hot strobe vector
module cpu_strobe_dec
   import cpu_seq_pkg::*;
#(
   parameter int NUM_REGS = 2,
   parameter int REG_W    = 1
) (
   input  logic [REG_W-1:0]    idx,
   input  logic                en,
   output logic [NUM_REGS-1:0] strobe_n
);

   always_comb begin
      strobe_n = '1;
      for (int i = 0; i < NUM_REGS; i++) begin
         if (en && (32'(idx) == i)) begin
            strobe_n[i] = 1'b0;
         end
      end
   end

endmodule

// File: rtl/cpu_bus_sequencer.sv
// rtl/cpu_bus_sequencer.sv - sequences register writes/reads and ALU operations onto the CPU databus
module cpu_bus_sequencer
   import cpu_seq_pkg::*;
#(
   parameter  int DATA_W   = 8,
   parameter  int NUM_REGS = 2,
   parameter  int OPC_W    = 4,
   localparam int REG_W    = (NUM_REGS > 1) ? $clog2(NUM_REGS) : 1
) (
   input  logic                i_pld_clk,
   input  logic                i_pld_rst,
   input  logic                i_cmd_valid,
   output logic                o_cmd_ready,
   input  logic [1:0]          i_cmd_type,
   input  logic [REG_W-1:0]    i_cmd_reg_a,
   input  logic [REG_W-1:0]    i_cmd_reg_b,
   input  logic [DATA_W-1:0]   i_cmd_data_a,
   input  logic [DATA_W-1:0]   i_cmd_data_b,
   input  logic [OPC_W-1:0]    i_cmd_opcode,
   input  logic                i_cmd_cin,
   input  logic                i_cmd_flag_en,
   output logic                o_rsp_valid,
   input  logic                i_rsp_ready,
   output logic [DATA_W-1:0]   o_rsp_data,
   output logic                o_rsp_err,
   output logic [NUM_REGS-1:0] o_reg_wrtn,
   output logic [NUM_REGS-1:0] o_reg_rdn,
   output logic [DATA_W-1:0]   o_bus_data,
   output logic                o_bus_oe,
   input  logic [DATA_W-1:0]   i_bus_data,
   output logic [OPC_W-1:0]    o_alu_opcode,
   output logic                o_alu_cin,
   output logic                o_alu_sel,
   output logic                o_alu_flag_sel
);

   seq_state_e          state, nxt_state;
   cmd_type_e           cmd_type, nxt_type, in_type;
   logic [REG_W-1:0]    reg_a, reg_b, nxt_reg_a, nxt_reg_b;
   logic [DATA_W-1:0]   data_a, data_b, nxt_data_a, nxt_data_b;
   logic [OPC_W-1:0]    opcode, nxt_opcode;
   logic                cin, nxt_cin, flag_en, nxt_flag_en;
   logic                phase_b, nxt_phase_b;
   logic                accept, cmd_bad;
   logic                wr_en, rd_en, nxt_oe, nxt_alu_sel;
   logic [REG_W-1:0]    wr_idx;
   logic [NUM_REGS-1:0] nxt_wrtn, nxt_rdn;

   function automatic logic idx_bad(input logic [REG_W-1:0] idx);
      return 32'(idx) >= $unsigned(NUM_REGS);
   endfunction

   assign o_cmd_ready = (state == S_IDLE);
   assign accept      = i_cmd_valid && o_cmd_ready;
   assign in_type     = cmd_type_e'(i_cmd_type);
   assign cmd_bad     = idx_bad(i_cmd_reg_a) || ((in_type == CMD_ALU) && idx_bad(i_cmd_reg_b));

   // Fields seen by the output decode: fresh command on the accept edge, latched copy otherwise
   always_comb begin
      nxt_type    = accept ? in_type       : cmd_type;
      nxt_reg_a   = accept ? i_cmd_reg_a   : reg_a;
      nxt_reg_b   = accept ? i_cmd_reg_b   : reg_b;
      nxt_data_a  = accept ? i_cmd_data_a  : data_a;
      nxt_data_b  = accept ? i_cmd_data_b  : data_b;
      nxt_opcode  = accept ? i_cmd_opcode  : opcode;
      nxt_cin     = accept ? i_cmd_cin     : cin;
      nxt_flag_en = accept ? i_cmd_flag_en : flag_en;
   end

   always_comb begin
      nxt_state   = state;
      nxt_phase_b = phase_b;
      case (state)
         S_IDLE: begin
            if (accept) begin
               nxt_phase_b = 1'b0;
               if (cmd_bad) begin
                  nxt_state = S_RSP;
               end else begin
                  case (in_type)
                     CMD_WRITE:   nxt_state = S_WR_STB;
                     CMD_READ:    nxt_state = S_RD_STB;
                     CMD_ALU:     nxt_state = S_WR_STB;
                     CMD_ALU_REG: nxt_state = S_ALU_SET;
                     default:     nxt_state = S_RSP;
                  endcase
               end
            end
         end
         S_WR_STB:  nxt_state = S_WR_HOLD;
         S_WR_HOLD: begin
            // ALU commands loop back once to load the B operand register
            if (cmd_type == CMD_ALU && !phase_b) begin
               nxt_state   = S_WR_STB;
               nxt_phase_b = 1'b1;
            end else if (cmd_type == CMD_ALU) begin
               nxt_state = S_ALU_SET;
            end else begin
               nxt_state = S_RSP;
            end
         end
         S_RD_STB:  nxt_state = S_RD_CAP;
         S_RD_CAP:  nxt_state = S_RSP;
         S_ALU_SET: nxt_state = S_ALU_CAP;
         S_ALU_CAP: nxt_state = S_RSP;
         S_RSP: begin
            if (i_rsp_ready) begin
               nxt_state = S_IDLE;
            end
         end
         default:   nxt_state = S_IDLE;
      endcase
   end

   assign wr_en       = (nxt_state == S_WR_STB);
   assign wr_idx      = nxt_phase_b ? nxt_reg_b : nxt_reg_a;
   assign rd_en       = (nxt_state == S_RD_STB) || (nxt_state == S_RD_CAP);
   assign nxt_oe      = (nxt_state == S_WR_STB) || (nxt_state == S_WR_HOLD);
   assign nxt_alu_sel = (nxt_state == S_ALU_SET) || (nxt_state == S_ALU_CAP);

   cpu_strobe_dec #(.NUM_REGS(NUM_REGS), .REG_W(REG_W)) u_wr_dec (
      .idx      (wr_idx),
      .en       (wr_en),
      .strobe_n (nxt_wrtn)
   );

   cpu_strobe_dec #(.NUM_REGS(NUM_REGS), .REG_W(REG_W)) u_rd_dec (
      .idx      (nxt_reg_a),
      .en       (rd_en),
      .strobe_n (nxt_rdn)
   );

   always_ff @(posedge i_pld_clk) begin
      if (i_pld_rst) begin
         state          <= S_IDLE;
         cmd_type       <= CMD_WRITE;
         reg_a          <= '0;
         reg_b          <= '0;
         data_a         <= '0;
         data_b         <= '0;
         opcode         <= '0;
         cin            <= 1'b0;
         flag_en        <= 1'b0;
         phase_b        <= 1'b0;
         o_reg_wrtn     <= '1;
         o_reg_rdn      <= '1;
         o_bus_oe       <= 1'b0;
         o_bus_data     <= '0;
         o_alu_sel      <= 1'b0;
         o_alu_flag_sel <= 1'b0;
         o_alu_opcode   <= '0;
         o_alu_cin      <= 1'b0;
         o_rsp_valid    <= 1'b0;
         o_rsp_data     <= '0;
         o_rsp_err      <= 1'b0;
      end else begin
         state          <= nxt_state;
         cmd_type       <= nxt_type;
         reg_a          <= nxt_reg_a;
         reg_b          <= nxt_reg_b;
         data_a         <= nxt_data_a;
         data_b         <= nxt_data_b;
         opcode         <= nxt_opcode;
         cin            <= nxt_cin;
         flag_en        <= nxt_flag_en;
         phase_b        <= nxt_phase_b;
         o_reg_wrtn     <= nxt_wrtn;
         o_reg_rdn      <= nxt_rdn;
         o_bus_oe       <= nxt_oe;
         o_bus_data     <= nxt_oe ? (nxt_phase_b ? nxt_data_b : nxt_data_a) : '0;
         o_alu_sel      <= nxt_alu_sel;
         o_alu_flag_sel <= nxt_alu_sel && nxt_flag_en;
         o_alu_opcode   <= nxt_alu_sel ? nxt_opcode : '0;
         o_alu_cin      <= nxt_alu_sel && nxt_cin;
         o_rsp_valid    <= (nxt_state == S_RSP);
         if (accept) begin
            o_rsp_err  <= cmd_bad;
            o_rsp_data <= '0;
         end else begin
            case (state)
               S_WR_HOLD: o_rsp_data <= phase_b ? data_b : data_a;
               S_RD_CAP:  o_rsp_data <= i_bus_data;
               S_ALU_CAP: o_rsp_data <= i_bus_data;
               default:   o_rsp_data <= o_rsp_data;
            endcase
         end
      end
   end

endmodule

// File: tb/tb_cpu_bus_sequencer.sv
// tb/tb_cpu_bus_sequencer.sv - self-checking bench with register/ALU environment and transaction-level expectation model
module tb_cpu_bus_sequencer;
   import cpu_seq_pkg::*;

   localparam int NR = 3;

   logic        clk = 1'b0;
   logic        rst;
   logic        cmd_valid, cmd_ready;
   logic [1:0]  cmd_type;
   logic [1:0]  cmd_reg_a, cmd_reg_b;
   logic [7:0]  cmd_data_a, cmd_data_b;
   logic [3:0]  cmd_opcode;
   logic        cmd_cin, cmd_flag_en;
   logic        rsp_valid, rsp_ready, rsp_err;
   logic [7:0]  rsp_data;
   logic [NR-1:0] reg_wrtn, reg_rdn;
   logic [7:0]  bus_out, bus_in;
   logic        bus_oe;
   logic [3:0]  alu_opcode;
   logic        alu_cin, alu_sel, alu_flag_sel;

   logic [7:0]  env_regs [NR];
   logic [7:0]  ref_regs [NR];

   typedef struct packed {
      logic          ready;
      logic [NR-1:0] wrtn;
      logic [NR-1:0] rdn;
      logic          oe;
      logic [7:0]    bus;
      logic          sel;
      logic          flag;
      logic [3:0]    opc;
      logic          cin;
      logic          rv;
      logic [7:0]    rd;
      logic          re;
   } exp_t;

   exp_t exp_q [$];
   int   checks = 0;
   int   errors = 0;
   bit   chk_en = 1'b0;
   logic [7:0] got;
   logic       got_err;

   always #5 clk = ~clk;

   cpu_bus_sequencer #(.DATA_W(8), .NUM_REGS(NR), .OPC_W(4)) dut (
      .i_pld_clk      (clk),
      .i_pld_rst      (rst),
      .i_cmd_valid    (cmd_valid),
      .o_cmd_ready    (cmd_ready),
      .i_cmd_type     (cmd_type),
      .i_cmd_reg_a    (cmd_reg_a),
      .i_cmd_reg_b    (cmd_reg_b),
      .i_cmd_data_a   (cmd_data_a),
      .i_cmd_data_b   (cmd_data_b),
      .i_cmd_opcode   (cmd_opcode),
      .i_cmd_cin      (cmd_cin),
      .i_cmd_flag_en  (cmd_flag_en),
      .o_rsp_valid    (rsp_valid),
      .i_rsp_ready    (rsp_ready),
      .o_rsp_data     (rsp_data),
      .o_rsp_err      (rsp_err),
      .o_reg_wrtn     (reg_wrtn),
      .o_reg_rdn      (reg_rdn),
      .o_bus_data     (bus_out),
      .o_bus_oe       (bus_oe),
      .i_bus_data     (bus_in),
      .o_alu_opcode   (alu_opcode),
      .o_alu_cin      (alu_cin),
      .o_alu_sel      (alu_sel),
      .o_alu_flag_sel (alu_flag_sel)
   );

   function automatic logic [7:0] alu_ref(logic [7:0] a, logic [7:0] b, logic [3:0] opc, logic c);
      case (opc)
         ALU_ADD: return a + b + {7'd0, c};
         ALU_SUB: return a - b - {7'd0, c};
         ALU_AND: return a & b;
         ALU_OR:  return a | b;
         ALU_XOR: return a ^ b;
         default: return a;
      endcase
   endfunction

   // Register file and ALU as seen from the databus: registers latch on a low write strobe
   always @(posedge clk) begin
      if (rst && !chk_en) begin
         env_regs[0] <= 8'h00;
         env_regs[1] <= 8'hC3;
         env_regs[2] <= 8'h77;
      end else begin
         for (int i = 0; i < NR; i++) begin
            if (!reg_wrtn[i]) env_regs[i] <= bus_out;
         end
      end
   end

   always_comb begin
      bus_in = bus_oe ? bus_out : 8'h00;
      for (int i = 0; i < NR; i++) begin
         if (!reg_rdn[i]) bus_in = env_regs[i];
      end
      if (alu_sel) bus_in = alu_ref(env_regs[0], env_regs[1], alu_opcode, alu_cin);
   end

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
      checks++;
      if (act !== req) begin
         errors++;
         $display("FAIL %s: got 0x%0h, required 0x%0h at %0t", name, act, req, $time);
      end
   endtask

   function automatic exp_t idle_e();
      exp_t e = '0;
      e.ready = 1'b1;
      e.wrtn  = '1;
      e.rdn   = '1;
      return e;
   endfunction

   function automatic exp_t busy_e();
      exp_t e = idle_e();
      e.ready = 1'b0;
      return e;
   endfunction

   function automatic exp_t ws_e(int idx, logic [7:0] d);
      exp_t e = busy_e();
      e.wrtn[idx] = 1'b0;
      e.oe  = 1'b1;
      e.bus = d;
      return e;
   endfunction

   function automatic exp_t wh_e(logic [7:0] d);
      exp_t e = busy_e();
      e.oe  = 1'b1;
      e.bus = d;
      return e;
   endfunction

   function automatic exp_t rs_e(int idx);
      exp_t e = busy_e();
      e.rdn[idx] = 1'b0;
      return e;
   endfunction

   function automatic exp_t alu_e(logic [3:0] opc, logic c, logic fe);
      exp_t e = busy_e();
      e.sel  = 1'b1;
      e.flag = fe;
      e.opc  = opc;
      e.cin  = c;
      return e;
   endfunction

   function automatic exp_t rsp_e(logic [7:0] d, logic er);
      exp_t e = busy_e();
      e.rv = 1'b1;
      e.rd = d;
      e.re = er;
      return e;
   endfunction

   always @(negedge clk) begin
      exp_t e;
      if (chk_en) begin
         e = (exp_q.size() > 0) ? exp_q.pop_front() : idle_e();
         chk("cmd_ready", 32'(cmd_ready), 32'(e.ready));
         chk("reg_wrtn", 32'(reg_wrtn), 32'(e.wrtn));
         chk("reg_rdn", 32'(reg_rdn), 32'(e.rdn));
         chk("bus_oe", 32'(bus_oe), 32'(e.oe));
         if (e.oe) chk("bus_data", 32'(bus_out), 32'(e.bus));
         chk("alu_sel", 32'(alu_sel), 32'(e.sel));
         chk("alu_flag_sel", 32'(alu_flag_sel), 32'(e.flag));
         if (e.sel) begin
            chk("alu_opcode", 32'(alu_opcode), 32'(e.opc));
            chk("alu_cin", 32'(alu_cin), 32'(e.cin));
         end
         chk("rsp_valid", 32'(rsp_valid), 32'(e.rv));
         if (e.rv) begin
            chk("rsp_data", 32'(rsp_data), 32'(e.rd));
            chk("rsp_err", 32'(rsp_err), 32'(e.re));
         end
      end
   end

   // Issue one command from an IDLE cycle, queue its cycle-by-cycle expectation, hold the response w cycles
   task automatic issue(input logic [1:0] t, input int ra, input int rb, input logic [7:0] da,
                        input logic [7:0] db, input logic [3:0] opc, input logic c, input logic fe,
                        input int w, output logic [7:0] r_data, output logic r_err);
      bit   bad;
      int   len;
      logic [7:0] res;
      cmd_valid   = 1'b1;
      cmd_type    = t;
      cmd_reg_a   = 2'(ra);
      cmd_reg_b   = 2'(rb);
      cmd_data_a  = da;
      cmd_data_b  = db;
      cmd_opcode  = opc;
      cmd_cin     = c;
      cmd_flag_en = fe;
      @(posedge clk);
      #1;
      cmd_valid = 1'b0;
      bad = (ra >= NR) || ((t == CMD_ALU) && (rb >= NR));
      len = 0;
      res = 8'h00;
      if (!bad) begin
         if (t == CMD_WRITE || t == CMD_ALU) begin
            exp_q.push_back(ws_e(ra, da));
            exp_q.push_back(wh_e(da));
            ref_regs[ra] = da;
            res = da;
            len += 2;
         end
         if (t == CMD_ALU) begin
            exp_q.push_back(ws_e(rb, db));
            exp_q.push_back(wh_e(db));
            ref_regs[rb] = db;
            len += 2;
         end
         if (t == CMD_READ) begin
            exp_q.push_back(rs_e(ra));
            exp_q.push_back(rs_e(ra));
            res = ref_regs[ra];
            len += 2;
         end
         if (t == CMD_ALU || t == CMD_ALU_REG) begin
            exp_q.push_back(alu_e(opc, c, fe));
            exp_q.push_back(alu_e(opc, c, fe));
            res = alu_ref(ref_regs[0], ref_regs[1], opc, c);
            len += 2;
         end
      end
      for (int i = 0; i <= w; i++) exp_q.push_back(rsp_e(res, bad));
      len += 1;
      repeat (len - 1) @(posedge clk);
      #1;
      r_data = rsp_data;
      r_err  = rsp_err;
      repeat (w) @(posedge clk);
      #1;
      rsp_ready = 1'b1;
      @(posedge clk);
      #1;
      rsp_ready = 1'b0;
   endtask

   initial begin
      rst = 1'b1;
      cmd_valid = 1'b0;
      cmd_type = 2'd0;
      cmd_reg_a = 2'd0;
      cmd_reg_b = 2'd0;
      cmd_data_a = 8'h00;
      cmd_data_b = 8'h00;
      cmd_opcode = 4'h0;
      cmd_cin = 1'b0;
      cmd_flag_en = 1'b0;
      rsp_ready = 1'b0;
      ref_regs[0] = 8'h00;
      ref_regs[1] = 8'hC3;
      ref_regs[2] = 8'h77;
      repeat (3) @(posedge clk);
      #1;
      rst = 1'b0;
      chk_en = 1'b1;
      chk("reset_cmd_ready", 32'(cmd_ready), 32'd1);
      chk("reset_wrtn", 32'(reg_wrtn), 32'h7);
      chk("reset_rdn", 32'(reg_rdn), 32'h7);
      chk("reset_bus_oe", 32'(bus_oe), 32'd0);
      chk("reset_bus_data", 32'(bus_out), 32'd0);
      chk("reset_alu_sel", 32'(alu_sel), 32'd0);
      chk("reset_rsp_valid", 32'(rsp_valid), 32'd0);

      issue(CMD_WRITE, 0, 0, 8'h5A, 8'h00, ALU_ADD, 1'b0, 1'b0, 0, got, got_err);
      chk("write_rsp", 32'(got), 32'h5A);
      chk("write_err", 32'(got_err), 32'd0);
      issue(CMD_READ, 1, 0, 8'h00, 8'h00, ALU_ADD, 1'b0, 1'b0, 0, got, got_err);
      chk("read_rsp", 32'(got), 32'hC3);
      issue(CMD_ALU, 0, 1, 8'h0F, 8'h01, ALU_ADD, 1'b0, 1'b1, 0, got, got_err);
      chk("alu_rsp", 32'(got), 32'h10);
      issue(CMD_ALU_REG, 0, 1, 8'hEE, 8'hEE, ALU_XOR, 1'b0, 1'b0, 0, got, got_err);
      chk("alu_reg_rsp", 32'(got), 32'h0E);
      issue(CMD_READ, 3, 0, 8'h00, 8'h00, ALU_ADD, 1'b0, 1'b0, 0, got, got_err);
      chk("reject_read_data", 32'(got), 32'h00);
      chk("reject_read_err", 32'(got_err), 32'd1);
      issue(CMD_ALU, 2, 2, 8'h11, 8'h22, ALU_ADD, 1'b1, 1'b1, 0, got, got_err);
      chk("alu_same_reg_rsp", 32'(got), 32'h11);
      issue(CMD_READ, 2, 0, 8'h00, 8'h00, ALU_ADD, 1'b0, 1'b0, 0, got, got_err);
      chk("same_reg_b_wins", 32'(got), 32'h22);
      issue(CMD_WRITE, 2, 0, 8'hA5, 8'h00, ALU_ADD, 1'b0, 1'b0, 5, got, got_err);
      chk("backpressure_rsp", 32'(got), 32'hA5);
      issue(CMD_ALU, 0, 3, 8'h44, 8'h55, ALU_OR, 1'b0, 1'b1, 2, got, got_err);
      chk("reject_alu_b_err", 32'(got_err), 32'd1);

      // Reset lands on the WR_STB cycle of a write
      cmd_valid  = 1'b1;
      cmd_type   = CMD_WRITE;
      cmd_reg_a  = 2'd1;
      cmd_data_a = 8'h99;
      @(posedge clk);
      #1;
      cmd_valid = 1'b0;
      exp_q.push_back(ws_e(1, 8'h99));
      rst = 1'b1;
      @(posedge clk);
      #1;
      rst = 1'b0;
      ref_regs[1] = 8'h99;
      chk("midrst_cmd_ready", 32'(cmd_ready), 32'd1);
      chk("midrst_wrtn", 32'(reg_wrtn), 32'h7);
      chk("midrst_rdn", 32'(reg_rdn), 32'h7);
      chk("midrst_bus_oe", 32'(bus_oe), 32'd0);
      chk("midrst_rsp_valid", 32'(rsp_valid), 32'd0);

      issue(CMD_WRITE, 0, 0, 8'h3C, 8'h00, ALU_ADD, 1'b0, 1'b0, 0, got, got_err);
      chk("post_rst_write", 32'(got), 32'h3C);
      issue(CMD_READ, 0, 0, 8'h00, 8'h00, ALU_ADD, 1'b0, 1'b0, 1, got, got_err);
      chk("post_rst_read", 32'(got), 32'h3C);

      repeat (3) @(posedge clk);
      #1;
      chk("queue_drained", 32'(exp_q.size()), 32'd0);
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
